// File: rtl/rr_byte_tx_arbiter.sv
// rtl/rr_byte_tx_arbiter.sv - round-robin arbiter feeding one LSB-first byte serializer
module rr_byte_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            i_Req,
  input  logic [NUM_REQ*DATAWIDTH-1:0]  i_Data,
  output logic [NUM_REQ-1:0]            o_Ack,
  output logic [7:0]                    o_ByteOut,
  output logic                          o_ByteOutValid,
  input  logic                          i_ByteOutReady,
  output logic                          o_ByteOutLast,
  output logic [$clog2(NUM_REQ)-1:0]    o_ByteOutSrc,
  output logic                          o_Busy
);

  localparam int NBYTES = (DATAWIDTH + 7) / 8;
  localparam int SW     = $clog2(NUM_REQ);
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]              state;
  logic [SW-1:0]           ptr;
  logic [SW-1:0]           src;
  logic [CW-1:0]           count;
  logic [NBYTES-1:0][7:0]  word;

  logic                    gnt_vld;
  logic [SW-1:0]           gnt_idx;
  logic [SW-1:0]           ptr_nxt;
  logic [NBYTES*8-1:0]     gnt_word;
  logic [7:0]              byte_sel;
  logic                    is_last;
  logic                    sending;

  // Scan offsets 0..NUM_REQ-1 from ptr; the first requester hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!gnt_vld && i_Req[r] && ((int'(ptr) + i) % NUM_REQ == r)) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(r);
        end
      end
    end
  end

  always_comb begin
    ptr_nxt = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  // Zero-extended copy of the granted word; upper pad bits stay 0.
  always_comb begin
    gnt_word = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt_idx == SW'(r)) begin
        gnt_word[DATAWIDTH-1:0] = i_Data[r*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_comb begin
    byte_sel = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (count == CW'(b)) begin
        byte_sel = word[b];
      end
    end
  end

  assign sending = (state == S_SEND);
  assign is_last = (count == CW'(NBYTES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      ptr   <= '0;
      src   <= '0;
      count <= '0;
      word  <= '0;
      o_Ack <= '0;
    end else begin
      o_Ack <= '0;
      if (state == S_IDLE) begin
        if (gnt_vld) begin
          word  <= gnt_word;
          ptr   <= ptr_nxt;
          src   <= gnt_idx;
          count <= '0;
          o_Ack <= NUM_REQ'(1) << gnt_idx;
          state <= S_SEND;
        end
      end else if (i_ByteOutReady) begin
        if (is_last) begin
          state <= S_IDLE;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  assign o_ByteOutValid = sending;
  assign o_Busy         = sending;
  assign o_ByteOutLast  = sending && is_last;
  assign o_ByteOut      = sending ? byte_sel : 8'h00;
  assign o_ByteOutSrc   = sending ? src : '0;

endmodule

// File: tb/tb_rr_byte_tx_arbiter.sv
// tb/tb_rr_byte_tx_arbiter.sv - scoreboard bench for rr_byte_tx_arbiter
module tb_rr_byte_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 20;
  localparam int NB = 3;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic [N-1:0]    ack;
  logic [7:0]      bout;
  logic            bvalid;
  logic            bready;
  logic            blast;
  logic [SW-1:0]   bsrc;
  logic            busy;

  logic [N-1:0]    req16;
  logic [N*16-1:0] data16;
  logic [N-1:0]    ack16;
  logic [7:0]      bout16;
  logic            v16;
  logic            l16;
  logic [SW-1:0]   src16;
  logic            busy16;

  rr_byte_tx_arbiter #(.NUM_REQ(N), .DATAWIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .i_Req(req), .i_Data(data), .o_Ack(ack),
    .o_ByteOut(bout), .o_ByteOutValid(bvalid), .i_ByteOutReady(bready),
    .o_ByteOutLast(blast), .o_ByteOutSrc(bsrc), .o_Busy(busy)
  );

  rr_byte_tx_arbiter #(.NUM_REQ(N), .DATAWIDTH(16)) dut16 (
    .clk(clk), .rstn(rstn), .i_Req(req16), .i_Data(data16), .o_Ack(ack16),
    .o_ByteOut(bout16), .o_ByteOutValid(v16), .i_ByteOutReady(1'b1),
    .o_ByteOutLast(l16), .o_ByteOutSrc(src16), .o_Busy(busy16)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out or unexpected", name);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       last;
    int         src;
  } exp_t;

  exp_t sbq[$];
  int   grant_log[$];

  logic [N-1:0]    req_at_edge;
  logic [N*DW-1:0] data_at_edge;
  logic            rdy_at_edge;
  bit              hold_all = 1'b0;

  always @(posedge clk) begin
    req_at_edge  <= req;
    data_at_edge <= data;
    rdy_at_edge  <= bready;
  end

  // Reference model: round-robin pick among requests seen at the grant edge,
  // bytes are the word shifted right 8 bits at a time.
  int m_ptr      = 0;
  bit idle_prev  = 1'b1;
  bit valid_prev = 1'b0;

  always @(negedge clk) begin
    exp_t        e;
    int          g;
    bit          idle_cur;
    bit          hs_last;
    logic [23:0] w;
    if (!rstn) begin
      sbq.delete();
      m_ptr      = 0;
      idle_prev  = 1'b1;
      valid_prev = 1'b0;
      chk("rst_valid", bvalid, 0);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_byte", bout, 0);
      chk("rst_last", blast, 0);
      chk("rst_src", bsrc, 0);
    end else begin
      hs_last = 1'b0;
      if (valid_prev && rdy_at_edge && sbq.size() > 0) begin
        e = sbq.pop_front();
        hs_last = e.last;
      end
      g = -1;
      if (idle_prev) begin
        for (int i = 0; i < N; i++) begin
          if (g < 0 && req_at_edge[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        end
      end
      if (g >= 0) begin
        chk("ack_grant", ack, 64'(1) << g);
        m_ptr = (g + 1) % N;
        grant_log.push_back(g);
        w = {4'h0, data_at_edge[g*DW +: DW]};
        for (int b = 0; b < NB; b++) begin
          e.b    = 8'((w >> (8 * b)) & 24'hFF);
          e.last = (b == NB - 1);
          e.src  = g;
          sbq.push_back(e);
        end
        idle_cur = 1'b0;
      end else begin
        chk("ack_quiet", ack, 0);
        idle_cur = idle_prev ? 1'b1 : hs_last;
      end
      chk("valid", bvalid, !idle_cur);
      chk("busy", busy, !idle_cur);
      if (bvalid) begin
        if (sbq.size() == 0) begin
          fail_now("unexpected_byte");
        end else begin
          chk("byte", bout, sbq[0].b);
          chk("last", blast, sbq[0].last);
          chk("src", bsrc, sbq[0].src);
        end
      end
      valid_prev = bvalid;
      idle_prev  = idle_cur;
    end
  end

  // Requesters drop i_Req once they see their ack.
  task automatic tick();
    @(negedge clk);
    #1;
    for (int r = 0; r < N; r++) begin
      if (ack[r] && !hold_all) req[r] = 1'b0;
    end
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while (!(req == 0 && !bvalid && sbq.size() == 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail_now(name);
    tick();
  endtask

  task automatic wait_ack(input int r, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack[r] && n < 50);
    if (!ack[r]) fail_now(name);
  endtask

  task automatic wait_grants(input int target, input string name);
    int n;
    n = 0;
    while (grant_log.size() < target && n < 200) begin
      tick();
      n++;
    end
    if (grant_log.size() < target) fail_now(name);
  endtask

  initial begin
    int base;
    rstn   = 1'b0;
    req    = '0;
    data   = '0;
    bready = 1'b1;
    req16  = '0;
    data16 = '0;
    repeat (3) @(negedge clk);
    #1;
    rstn = 1'b1;
    tick();

    // All four held: 0,1,2,3,0 with an idle cycle between words.
    base = grant_log.size();
    data = {20'hD4444, 20'hC3333, 20'hB2222, 20'hA1111};
    hold_all = 1'b1;
    req = 4'hF;
    wait_grants(base + 5, "rr_all_wait");
    req = '0;
    hold_all = 1'b0;
    if (grant_log.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) chk("rr_all_order", grant_log[base + k], k % N);
    end
    wait_quiet("rr_all_quiet");

    // Ptr=1 with req0 and req2: 2 first, then 0; then {0,1} shows Ptr back at 1.
    base = grant_log.size();
    req = 4'b0101;
    wait_grants(base + 2, "ptr1_wait");
    wait_quiet("ptr1_quiet");
    req = 4'b0011;
    wait_grants(base + 4, "ptr1b_wait");
    wait_quiet("ptr1b_quiet");
    if (grant_log.size() >= base + 4) begin
      chk("ptr1_first", grant_log[base], 2);
      chk("ptr1_second", grant_log[base + 1], 0);
      chk("ptr_end_1", grant_log[base + 2], 1);
    end

    // Single 20-bit word: 34,12,08 with Last on 08.
    data[0 +: DW] = 20'h81234;
    req = 4'b0001;
    wait_ack(0, "w20_ack");
    chk("w20_ack_vec", ack, 4'b0001);
    chk("w20_b0", bout, 8'h34);
    chk("w20_l0", blast, 0);
    chk("w20_src", bsrc, 0);
    tick();
    chk("w20_b1", bout, 8'h12);
    chk("w20_ack_pulse", ack, 0);
    tick();
    chk("w20_b2", bout, 8'h08);
    chk("w20_l2", blast, 1);
    tick();
    chk("w20_idle", bvalid, 0);
    wait_quiet("w20_quiet");

    // Backpressure on byte1 while the requester's data changes.
    data[0 +: DW] = 20'h81234;
    req = 4'b0001;
    wait_ack(0, "bp_ack");
    tick();
    bready = 1'b0;
    data[0 +: DW] = 20'hFFFFF;
    repeat (3) begin
      chk("bp_hold", bout, 8'h12);
      tick();
    end
    chk("bp_hold_last", bout, 8'h12);
    bready = 1'b1;
    tick();
    chk("bp_next", bout, 8'h08);
    chk("bp_next_last", blast, 1);
    wait_quiet("bp_quiet");

    // Reset after the first byte of 20'h12345.
    data[0 +: DW] = 20'h12345;
    req = 4'b0001;
    wait_ack(0, "rst_ack_wait");
    tick();
    chk("rst_pre_byte", bout, 8'h23);
    rstn = 1'b0;
    #1;
    chk("rst_async_valid", bvalid, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_ack", ack, 0);
    tick();
    tick();
    rstn = 1'b1;
    base = grant_log.size();
    data[1*DW +: DW] = 20'h5A5A5;
    data[2*DW +: DW] = 20'h0C3F0;
    req = 4'b0010;
    wait_quiet("post_rst1");
    req = 4'b0110;
    wait_grants(base + 3, "post_rst_wait");
    wait_quiet("post_rst2");
    if (grant_log.size() >= base + 3) begin
      chk("post_rst_src1", grant_log[base], 1);
      chk("post_rst_ptr2", grant_log[base + 1], 2);
      chk("post_rst_then1", grant_log[base + 2], 1);
    end

    // Randomized traffic with withdrawals, data churn and backpressure.
    repeat (3000) begin
      tick();
      for (int r = 0; r < N; r++) begin
        if (!req[r]) begin
          if ($urandom_range(3) == 0) begin
            req[r] = 1'b1;
            data[r*DW +: DW] = 20'($urandom);
          end else if ($urandom_range(1) == 0) begin
            data[r*DW +: DW] = 20'($urandom);
          end
        end else if ($urandom_range(15) == 0) begin
          req[r] = 1'b0;
        end
      end
      bready = ($urandom_range(3) != 0);
    end
    req = '0;
    bready = 1'b1;
    wait_quiet("rand_quiet");

    // 16-bit instance: exactly two bytes EF, BE.
    data16[15:0] = 16'hBEEF;
    req16 = 4'b0001;
    @(negedge clk);
    #1;
    chk("w16_ack", ack16, 4'b0001);
    chk("w16_b0", bout16, 8'hEF);
    chk("w16_l0", l16, 0);
    chk("w16_src", src16, 0);
    req16 = '0;
    @(negedge clk);
    #1;
    chk("w16_b1", bout16, 8'hBE);
    chk("w16_l1", l16, 1);
    chk("w16_v1", v16, 1);
    @(negedge clk);
    #1;
    chk("w16_done", v16, 0);
    chk("w16_busy", busy16, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
